// File: rtl/cobs_pkg.sv
// cobs_pkg: shared types and constants for the COBS receive decoder.
//   state_e       decoder FSM states
//   fifo_entry_t  one FIFO entry: start-of-frame tag plus decoded byte
package cobs_pkg;

    typedef enum logic [1:0] {
        ST_CODE,
        ST_DATA,
        ST_DISCARD
    } state_e;

    localparam logic [7:0] COBS_DELIM   = 8'h00;
    localparam logic [7:0] COBS_MAXCODE = 8'hFF;

    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through FIFO of {sof,data} entries.
//   clk, rst        clock, synchronous active-high reset (flushes pointers)
//   wr_en, wr_data  push; accepted when not full, or when full with rd_en
//   rd_en, rd_data  pop; rd_data is the current head (zero when empty)
//   full, empty     occupancy flags
//   level           current number of stored entries
module byte_fifo
    import cobs_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  fifo_entry_t              wr_data,
    input  logic                     rd_en,
    output fifo_entry_t              rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    fifo_entry_t    mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic           wr_fire, rd_fire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    // When full, a simultaneous read frees the slot the write lands in.
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    // Head is forced to zero when empty so the outputs read clean after reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cobs_rx_decoder.sv
// cobs_rx_decoder: streaming COBS decoder from the serial receiver to the
// command parser.
//   clk, rst                     clock, synchronous active-high reset
//   in_valid, in_data            raw received byte strobe (no backpressure)
//   out_valid, out_ready         FWFT handshake towards the parser
//   out_data, out_sof            decoded head byte and its start-of-frame tag
//   frame_end, err_trunc,        registered one-cycle event pulses
//   err_ovf
//   level                        FIFO occupancy
module cobs_rx_decoder
    import cobs_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_sof,
    output logic                     frame_end,
    output logic                     err_trunc,
    output logic                     err_ovf,
    output logic [$clog2(DEPTH):0]   level
);
    state_e      state_q, state_d;
    logic [7:0]  remain_q, remain_d;
    logic        pend_zero_q, pend_zero_d;
    logic        first_q, first_d;
    logic        started_q, started_d;
    logic        blk_ff_q, blk_ff_d;
    logic        frame_end_q, frame_end_d;
    logic        err_trunc_q, err_trunc_d;
    logic        err_ovf_q, err_ovf_d;

    logic        wr_req, wr_en, rd_en, refuse;
    logic [7:0]  wr_byte;
    logic        fifo_full, fifo_empty;
    fifo_entry_t head;

    assign out_valid = !fifo_empty;
    assign rd_en     = out_valid && out_ready;
    assign refuse    = fifo_full && !rd_en;
    assign wr_en     = wr_req && !refuse;
    assign out_data  = head.data;
    assign out_sof   = head.sof;
    assign frame_end = frame_end_q;
    assign err_trunc = err_trunc_q;
    assign err_ovf   = err_ovf_q;

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        pend_zero_d = pend_zero_q;
        first_d     = first_q;
        started_d   = started_q;
        blk_ff_d    = blk_ff_q;
        frame_end_d = 1'b0;
        err_trunc_d = 1'b0;
        err_ovf_d   = 1'b0;
        wr_req      = 1'b0;
        wr_byte     = in_data;

        if (in_valid) begin
            if (in_data == COBS_DELIM) begin
                case (state_q)
                    ST_CODE: frame_end_d = started_q;
                    ST_DATA: err_trunc_d = 1'b1;
                    default: ;
                endcase
                // Any owed zero is dropped: a frame never ends in an implied zero.
                state_d     = ST_CODE;
                started_d   = 1'b0;
                pend_zero_d = 1'b0;
                first_d     = 1'b1;
            end else begin
                case (state_q)
                    ST_CODE: begin
                        // The zero owed by the previous block is only emitted
                        // once another block proves it was not the last.
                        wr_req    = pend_zero_q;
                        wr_byte   = COBS_DELIM;
                        started_d = 1'b1;
                        blk_ff_d  = (in_data == COBS_MAXCODE);
                        remain_d  = in_data - 8'd1;
                        if (in_data == 8'd1) begin
                            pend_zero_d = 1'b1;
                        end else begin
                            pend_zero_d = 1'b0;
                            state_d     = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        wr_req   = 1'b1;
                        remain_d = remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            state_d     = ST_CODE;
                            // A full 0xFF block carries no implied zero.
                            pend_zero_d = !blk_ff_q;
                        end
                    end
                    default: ;
                endcase
                if (wr_req) begin
                    if (refuse) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_DISCARD;
                    end else begin
                        first_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CODE;
            remain_q    <= '0;
            pend_zero_q <= 1'b0;
            first_q     <= 1'b1;
            started_q   <= 1'b0;
            blk_ff_q    <= 1'b0;
            frame_end_q <= 1'b0;
            err_trunc_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            pend_zero_q <= pend_zero_d;
            first_q     <= first_d;
            started_q   <= started_d;
            blk_ff_q    <= blk_ff_d;
            frame_end_q <= frame_end_d;
            err_trunc_q <= err_trunc_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data ('{sof: first_q, data: wr_byte}),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

endmodule

// File: tb/tb_cobs_rx_decoder.sv
// Self-checking bench for cobs_rx_decoder: directed cases plus random COBS
// frames, scored against a payload-level reference model.
module tb_cobs_rx_decoder;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef logic [7:0] bq_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_ready = 1'b0;
    logic          out_valid, out_sof, frame_end, err_trunc, err_ovf;
    logic [7:0]    out_data;
    logic [LW-1:0] level;

    cobs_rx_decoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .frame_end (frame_end),
        .err_trunc (err_trunc),
        .err_ovf   (err_ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard state
    logic [8:0] exp_q [$];
    int fe_cnt = 0, tr_cnt = 0, ov_cnt = 0;
    int exp_fe = 0, exp_tr = 0, exp_ov = 0;
    bit held = 0;
    logic [8:0] held_v;
    int rdy_mode = 2;  // 0: always ready, 1: random, 2: never ready

    always @(negedge clk) begin
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0) || (level >= LW'(8));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        #1;
        if (rst) begin
            held = 0;
        end else begin
            if (frame_end) fe_cnt++;
            if (err_trunc) tr_cnt++;
            if (err_ovf)   ov_cnt++;
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_head", 32'({out_sof, out_data}), 32'(held_v));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", 32'(out_valid), 32'd0);
                else                   chk("out", 32'({out_sof, out_data}), 32'(exp_q.pop_front()));
            end
            held   = out_valid && !out_ready;
            held_v = {out_sof, out_data};
        end
    end

    // Reference: decode one frame (bytes between delimiters) block by block.
    task automatic decode_frame(input bq_t fr);
        int  i = 0;
        int  n = fr.size();
        bit  pend = 0, trunc = 0, sof = 1;
        int  c;
        if (n == 0) return;
        while (i < n && !trunc) begin
            c = int'(fr[i]);
            i++;
            if (pend) begin exp_q.push_back({sof, 8'h00}); sof = 0; end
            for (int k = 1; k < c; k++) begin
                if (i >= n) begin trunc = 1; break; end
                exp_q.push_back({sof, fr[i]});
                sof = 0;
                i++;
            end
            pend = (c != 255);
        end
        if (trunc) exp_tr++;
        else       exp_fe++;
    endtask

    task automatic model_stream(input bq_t s);
        bq_t fr;
        for (int i = 0; i < s.size(); i++) begin
            if (s[i] == 8'h00) begin decode_frame(fr); fr = {}; end
            else fr.push_back(s[i]);
        end
    endtask

    task automatic cobs_enc(input bq_t p, output bq_t e);
        bq_t blk;
        e = {};
        foreach (p[i]) begin
            if (p[i] == 8'h00) begin
                e.push_back(8'(blk.size() + 1)); foreach (blk[j]) e.push_back(blk[j]); blk = {};
            end else begin
                blk.push_back(p[i]);
                if (blk.size() == 254) begin
                    e.push_back(8'hFF); foreach (blk[j]) e.push_back(blk[j]); blk = {};
                end
            end
        end
        e.push_back(8'(blk.size() + 1));
        foreach (blk[j]) e.push_back(blk[j]);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); in_valid = 1'b0; end
    endtask

    task automatic send_seq(input bq_t s, input bit rnd);
        foreach (s[i]) send_byte(s[i], rnd ? int'($urandom_range(3)) : 2);
        idle(2);
    endtask

    task automatic drain_check(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin @(negedge clk); t++; end
        idle(4);
        #2;
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_fe"}, 32'(fe_cnt), 32'(exp_fe));
        chk({tag, "_trunc"}, 32'(tr_cnt), 32'(exp_tr));
        chk({tag, "_ovf"}, 32'(ov_cnt), 32'(exp_ov));
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        bq_t s, p, e;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sof", 32'(out_sof), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pulses", 32'({frame_end, err_trunc, err_ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 03 11 22 02 33 00, with first-byte latency checked while not ready
        exp_q.push_back(9'h111); exp_q.push_back(9'h022);
        exp_q.push_back(9'h000); exp_q.push_back(9'h033);
        exp_fe++;
        send_byte(8'h03, 2);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h11;
        #1 chk("lat_pre", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_level", 32'(level), 32'd1);
        chk("lat_head", 32'({out_sof, out_data}), 32'h111);
        rdy_mode = 0;
        s = {8'h22, 8'h02, 8'h33, 8'h00};
        send_seq(s, 0);
        drain_check("basic");

        // 01 01 01 00: two zeros, trailing one dropped
        exp_q.push_back(9'h100); exp_q.push_back(9'h000);
        exp_fe++;
        s = {8'h01, 8'h01, 8'h01, 8'h00};
        send_seq(s, 0);
        drain_check("zeros");

        // FF block then 02 AA: no zero after a full block
        rdy_mode = 1;
        s = {8'hFF};
        for (int v = 1; v <= 254; v++) s.push_back(8'(v));
        s.push_back(8'h02); s.push_back(8'hAA); s.push_back(8'h00);
        model_stream(s);
        send_seq(s, 1);
        drain_check("maxblk");

        // Truncated frame then a good one
        s = {8'h04, 8'h11, 8'h22, 8'h00, 8'h02, 8'h55, 8'h00};
        model_stream(s);
        send_seq(s, 0);
        drain_check("trunc");

        // Overflow with consumer stalled
        rdy_mode = 2;
        idle(2);
        send_byte(8'hFF, 2);
        for (int v = 1; v <= 16; v++) begin
            exp_q.push_back({(v == 1), 8'(v)});
            send_byte(8'(v), 2);
        end
        #2;
        chk("ovf_level16", 32'(level), 32'd16);
        chk("ovf_none_yet", 32'(ov_cnt), 32'(exp_ov));
        send_byte(8'd17, 2);
        exp_ov++;
        #2;
        chk("ovf_pulse", 32'(ov_cnt), 32'(exp_ov));
        chk("ovf_level_kept", 32'(level), 32'd16);
        s = {8'd18, 8'd19, 8'd20, 8'h00};
        send_seq(s, 0);
        rdy_mode = 1;
        drain_check("ovf");
        s = {8'h02, 8'h77, 8'h00};
        model_stream(s);
        send_seq(s, 0);
        drain_check("ovf_recover");

        // Reset mid-frame
        rdy_mode = 2;
        idle(2);
        send_byte(8'h03, 2);
        send_byte(8'h11, 2);
        #2 chk("mid_level", 32'(level), 32'd1);
        @(negedge clk); rst = 1'b1;
        idle(2);
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        rdy_mode = 1;
        s = {8'h02, 8'h99, 8'h00};
        model_stream(s);
        send_seq(s, 0);
        drain_check("post_rst");

        // Random frames: valid ones checked against the original payload
        for (int f = 0; f < 40; f++) begin
            int len;
            bit long_run = ($urandom_range(5) == 0);
            len = long_run ? int'($urandom_range(300, 250)) : int'($urandom_range(40));
            p = {};
            for (int i = 0; i < len; i++)
                p.push_back((!long_run && $urandom_range(4) == 0) ? 8'h00 : 8'($urandom_range(255, 1)));
            cobs_enc(p, e);
            if (e.size() > 1 && $urandom_range(4) == 0) begin
                int cut = int'($urandom_range(e.size() - 1, 1));
                s = {};
                for (int i = 0; i < cut; i++) s.push_back(e[i]);
                s.push_back(8'h00);
                model_stream(s);
            end else begin
                s = e;
                s.push_back(8'h00);
                foreach (p[i]) exp_q.push_back({(i == 0), p[i]});
                exp_fe++;
            end
            if ($urandom_range(3) == 0) s.push_back(8'h00);
            send_seq(s, 1);
        end
        drain_check("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cobs_rx_decoder.md
# cobs_rx_decoder

Streaming COBS decoder between the 8N1 serial receiver and the framebuffer/palette command parser. It takes raw received bytes (one-cycle strobe, no backpressure possible), strips COBS framing, and restores the encoded zero bytes. Decoded bytes go through a small first-word-fall-through FIFO to the parser over a valid/ready handshake. Each byte carries a start-of-frame tag, so the parser resets its command state on a tag rather than on raw 0x00 bytes.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO entries; power of two, at least 4.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  one-cycle strobe from the serial receiver.
- `in_data`  in  8  received raw byte; sampled when `in_valid`=1.
- `out_valid`  out  1  FIFO head holds a decoded byte.
- `out_ready`  in  1  consumer accepts the head byte this cycle.
- `out_data`  out  8  decoded byte at the FIFO head.
- `out_sof`  out  1  head byte is the first decoded byte of its frame.
- `frame_end`  out  1  one-cycle pulse: a frame was closed by a delimiter.
- `err_trunc`  out  1  one-cycle pulse: a delimiter arrived inside a code block.
- `err_ovf`  out  1  one-cycle pulse: a decoded byte was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Delimiter: 0x00. Code byte c is in 1..255 and is followed by c-1 data bytes.
- States:
  - ST_CODE: expect a code byte.
  - ST_DATA: copy data bytes; `remain` counter, 8 bits.
  - ST_DISCARD: drop input until a delimiter.
- Registers: `pend_zero` (an implied zero is owed), `first` (next write is tagged sof), `started` (frame has at least one code byte), `blk_ff` (current code is 0xFF).
- ST_CODE, non-zero byte c:
  - If `pend_zero`=1, write 0x00.
  - Set `started`=1. Set `blk_ff`=(c==0xFF). Set `remain`=c-1.
  - If c==1, set `pend_zero`=1 and stay in ST_CODE.
  - Otherwise clear `pend_zero` and go to ST_DATA.
- ST_DATA, non-zero byte:
  - Write the byte and decrement `remain`.
  - When `remain` reaches 0, go to ST_CODE and set `pend_zero`=!`blk_ff`.
- Delimiter in ST_CODE:
  - Drop any pending zero (no trailing zero is emitted).
  - If `started`=1, pulse `frame_end`.
  - Clear `started` and `pend_zero`. Set `first`=1.
- Delimiter in ST_DATA:
  - Pulse `err_trunc`; do not pulse `frame_end`.
  - Go to ST_CODE. Clear `started` and `pend_zero`. Set `first`=1.
- Delimiter in ST_DISCARD: go to ST_CODE; `first`=1, `started`=0, `pend_zero`=0. No pulses.
- Each input byte causes at most one FIFO write. Each write stores {`first`,byte}; `first` clears after the write.
- Overflow:
  - A write is refused only when the FIFO is full and no read happens in the same cycle.
  - On refusal: drop the byte, pulse `err_ovf`, go to ST_DISCARD.
  - Bytes already in the FIFO are kept.
- Reset: FIFO flushed, state ST_CODE, `first`=1, all other flags 0.
  - Outputs after reset: `out_valid`=0, `out_data`=0, `out_sof`=0, all pulses 0, `level`=0.

## Timing
- Input byte strobed at edge n is written at edge n. `out_valid` rises in cycle n+1 when the FIFO was empty. No combinational path from `in_*` to `out_*`.
- A head transfer happens at any edge with `out_valid`&&`out_ready`. `out_data`/`out_sof` show the next entry in the following cycle.
- A read and a write in the same cycle leave `level` unchanged, including when the FIFO is full.
- `out_data`/`out_sof` are don't-care when `out_valid`=0. They are held stable while `out_valid`=1 and `out_ready`=0.
- `frame_end`, `err_trunc` and `err_ovf` are registered and assert in cycle n+1 for the delimiter or byte strobed at edge n.
- Input byte spacing is at least 2 cycles (serial receiver). Back-to-back strobes must still decode correctly.

## Structure
- Package `cobs_pkg`:
  - state enum {ST_CODE, ST_DATA, ST_DISCARD}
  - `COBS_DELIM`=8'h00
  - `COBS_MAXCODE`=8'hFF
- Sub-module `byte_fifo`:
  - synchronous FWFT FIFO, 9-bit entries {sof,data}
  - parameter `DEPTH`
  - ports: write enable, read enable, full, empty, level
- The decoder FSM lives in the top module and holds the `remain` counter and the flags.

## Test plan
- Reset, then 03 11 22 02 33 00 with `out_ready`=1 → outputs 11(sof),22,00,33; one `frame_end`; no errors.
- Send 01 01 01 00 → outputs 00(sof),00 (third zero dropped); one `frame_end`.
- Send FF, then bytes 01..FE, then 02 AA 00 → 255 outputs 01..FE,AA with no inserted zero; sof on 01 only.
- Send 04 11 22 00, then 02 55 00 → 11(sof),22; `err_trunc` pulse and no `frame_end`. Then 55(sof); `frame_end`.
- DEPTH=16, `out_ready`=0: send FF plus 20 data bytes, then 00 → `level`=16, `err_ovf` pulse on the 17th byte, rest discarded. Drain, then send 02 77 00 → 77(sof).
- Assert `rst` mid-frame after 03 11 → FIFO empty, `level`=0. Then 02 99 00 with random `out_ready` toggling → 99(sof), held stable until accepted.
